// File: rtl/imem_loader_if.sv
// Byte-stream source and InstructionRAM write port seen by the boot loader.
// master = byte source / RAM side, slave = loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words, writes
// them to InstructionRAM at consecutive addresses, and releases cpu_run after HALT_WORD.
module imem_loader #(
    parameter int          ADDR_WIDTH = 9,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum
);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t              state, nextState;
    logic [1:0]          byteIdx;
    logic [31:0]         wordBuf;
    logic [ADDR_WIDTH:0] wordCount;
    logic [31:0]         checksumQ;
    logic                byteFire;
    logic                restart;

    // byte_ready is decoded from state alone, so valid never reaches ready combinationally.
    assign byteFire = bus.byte_valid && (state == RECV);
    assign restart  = start && ((state == IDLE) || (state == DONE) || (state == ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (start) nextState = RECV;
            RECV:  if (byteFire && (byteIdx == 2'd3)) nextState = WRITE;
            // Halt has priority over full, so a halt in the last slot still completes.
            WRITE: begin
                if (wordBuf == HALT_WORD)       nextState = DONE;
                else if (wordCount == LAST_ADDR) nextState = ERR;
                else                             nextState = RECV;
            end
            DONE:  if (start) nextState = RECV;
            ERR:   if (start) nextState = RECV;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteIdx   <= '0;
            wordBuf   <= '0;
            wordCount <= '0;
            checksumQ <= '0;
        end else if (restart) begin
            byteIdx   <= '0;
            wordBuf   <= '0;
            wordCount <= '0;
            checksumQ <= '0;
        end else if (byteFire) begin
            wordBuf <= {wordBuf[23:0], bus.byte_data};
            byteIdx <= byteIdx + 2'd1;
        end else if (state == WRITE) begin
            byteIdx   <= '0;
            checksumQ <= checksumQ + wordBuf;
            if (wordCount != FULL_COUNT)
                wordCount <= wordCount + (ADDR_WIDTH+1)'(1);
        end
    end

    assign bus.byte_ready = (state == RECV);
    assign bus.ram_we     = (state == WRITE);
    assign bus.ram_addr   = (state == WRITE) ? wordCount[ADDR_WIDTH-1:0] : '0;
    assign bus.ram_wdata  = (state == WRITE) ? wordBuf : '0;
    assign cpu_run        = (state == DONE);
    assign busy           = (state == RECV) || (state == WRITE);
    assign overflow_err   = (state == ERR);
    assign word_count     = wordCount;
    assign checksum       = checksumQ;

    a_weSingle: assert property (@(posedge clk) disable iff (!rst_n) bus.ram_we |=> !bus.ram_we);
    a_cntBound: assert property (@(posedge clk) disable iff (!rst_n) wordCount <= FULL_COUNT);
    a_runIdle:  assert property (@(posedge clk) disable iff (!rst_n) !(cpu_run && busy));
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (512-word and 4-word RAM) checked
// against a word-level reference model of the load.
module tb_imem_loader;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start9 = 1'b0, start2 = 1'b0;
    logic        run9, busy9, ovf9, run2, busy2, ovf2;
    logic [9:0]  wc9;
    logic [2:0]  wc2;
    logic [31:0] cs9, cs2;

    imem_loader_if #(.ADDR_WIDTH(9)) bus9 ();
    imem_loader_if #(.ADDR_WIDTH(2)) bus2 ();

    imem_loader #(.ADDR_WIDTH(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .bus(bus9),
        .cpu_run(run9), .busy(busy9), .overflow_err(ovf9),
        .word_count(wc9), .checksum(cs9)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
        .cpu_run(run2), .busy(busy2), .overflow_err(ovf2),
        .word_count(wc2), .checksum(cs2)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed RAM writes from either instance (only one is active at a time).
    logic [63:0] obsQ[$];
    logic [31:0] tbRam    [2][512];
    logic [31:0] modelRam [2][512];

    always @(negedge clk) begin
        if (bus9.ram_we) begin
            obsQ.push_back({32'(bus9.ram_addr), bus9.ram_wdata});
            tbRam[0][bus9.ram_addr] = bus9.ram_wdata;
        end
        if (bus2.ram_we) begin
            obsQ.push_back({32'(bus2.ram_addr), bus2.ram_wdata});
            tbRam[1][32'(bus2.ram_addr)] = bus2.ram_wdata;
        end
    end

    // Reference model: group the stream into big-endian words, stop at halt or a full RAM.
    logic [7:0]  stream[$];
    logic [63:0] expQ[$];
    int          expWc;
    logic [31:0] expCs;
    bit          expRun, expErr;
    int          nUse;

    function automatic void model(input int sel);
        int cap;
        logic [31:0] w;
        cap = (sel != 0) ? 4 : 512;
        expQ.delete();
        expWc = 0; expCs = '0; expRun = 0; expErr = 0;
        for (int i = 0; 4*i+3 < stream.size(); i++) begin
            w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
            expQ.push_back({32'(i), w});
            modelRam[sel][i] = w;
            expCs = expCs + w;
            expWc++;
            if (w == HALT) begin expRun = 1; break; end
            if (expWc == cap) begin expErr = 1; break; end
        end
        nUse = 4 * expWc;
    endfunction

    task automatic setByte(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin bus9.byte_valid = v; bus9.byte_data = d; end
        else          begin bus2.byte_valid = v; bus2.byte_data = d; end
    endtask

    task automatic setStart(input int sel, input logic v);
        if (sel == 0) start9 = v;
        else          start2 = v;
    endtask

    task automatic readStat(input int sel, output logic run, output logic busy, output logic ovf,
                            output logic rdy, output logic we, output logic [31:0] wc,
                            output logic [31:0] cs, output logic [31:0] addr, output logic [31:0] wd);
        if (sel == 0) begin
            run = run9; busy = busy9; ovf = ovf9; rdy = bus9.byte_ready; we = bus9.ram_we;
            wc = 32'(wc9); cs = cs9; addr = 32'(bus9.ram_addr); wd = bus9.ram_wdata;
        end else begin
            run = run2; busy = busy2; ovf = ovf2; rdy = bus2.byte_ready; we = bus2.ram_we;
            wc = 32'(wc2); cs = cs2; addr = 32'(bus2.ram_addr); wd = bus2.ram_wdata;
        end
    endtask

    task automatic checkReset(input int sel, input string tag);
        logic run, busy, ovf, rdy, we;
        logic [31:0] wc, cs, addr, wd;
        readStat(sel, run, busy, ovf, rdy, we, wc, cs, addr, wd);
        chk({tag, "/outs"}, {run, busy, ovf, rdy, we}, 5'b0);
        chk({tag, "/wc"}, wc, 0);
        chk({tag, "/cs"}, cs, 0);
        chk({tag, "/addr_wdata"}, {addr, wd}, 0);
    endtask

    // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid plus stray starts.
    task automatic runLoad(input int sel, input int mode, input string tag);
        logic run, busy, ovf, rdy, we;
        logic [31:0] wc, cs, addr, wd;
        int idx, cnt, limit, mism, cap;
        logic v;
        model(sel);
        obsQ.delete();
        idx = 0; cnt = 0; limit = 8*nUse + 50;
        cap = (sel != 0) ? 4 : 512;
        @(negedge clk); setStart(sel, 1'b1);
        @(negedge clk); setStart(sel, 1'b0);
        readStat(sel, run, busy, ovf, rdy, we, wc, cs, addr, wd);
        chk({tag, "/start_run"}, run, 1'b0);
        chk({tag, "/start_busy_ovf"}, {busy, ovf}, 2'b10);
        chk({tag, "/start_clear"}, {wc, cs}, 0);
        while (idx < nUse && cnt < limit) begin
            readStat(sel, run, busy, ovf, rdy, we, wc, cs, addr, wd);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cnt % 2 == 0);
                default: v = ($urandom_range(2) != 0);
            endcase
            setByte(sel, v, stream[idx]);
            setStart(sel, (mode == 2) && ($urandom_range(7) == 0));
            if (v && rdy) idx++;
            @(negedge clk); cnt++;
        end
        setByte(sel, 1'b0, 8'h00);
        setStart(sel, 1'b0);
        readStat(sel, run, busy, ovf, rdy, we, wc, cs, addr, wd);
        while (!(run || ovf) && cnt < limit + 10) begin
            @(negedge clk); cnt++;
            readStat(sel, run, busy, ovf, rdy, we, wc, cs, addr, wd);
        end
        chk({tag, "/consumed"}, 64'(idx), 64'(nUse));
        if (mode == 0) chk({tag, "/cycles"}, 64'(cnt), 64'(5*expWc));
        chk({tag, "/nwrites"}, 64'(obsQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
            chk($sformatf("%s/wr%0d", tag, i), obsQ[i], expQ[i]);
        chk({tag, "/wc"}, wc, 32'(expWc));
        chk({tag, "/cs"}, cs, expCs);
        chk({tag, "/run_ovf_busy"}, {run, ovf, busy}, {expRun, expErr, 1'b0});
        mism = 0;
        for (int a = 0; a < cap; a++)
            if (tbRam[sel][a] !== modelRam[sel][a]) mism++;
        chk({tag, "/ram"}, 64'(mism), 0);
    endtask

    task automatic loadT1();
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        int sel, nw;
        bit halt;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 512; a++) begin tbRam[s][a] = '0; modelRam[s][a] = '0; end
        setByte(0, 1'b0, 8'h00);
        setByte(1, 1'b0, 8'h00);
        #1;
        checkReset(0, "rst9");
        checkReset(1, "rst2");
        @(negedge clk); rst_n = 1'b1;

        // Bytes offered while idle must be ignored.
        bus9.byte_valid = 1'b1; bus9.byte_data = 8'hA5;
        repeat (3) @(negedge clk);
        bus9.byte_valid = 1'b0;
        checkReset(0, "idle9");
        chk("idle/nowr", 64'(obsQ.size()), 0);

        loadT1(); runLoad(0, 0, "t1");
        chk("t1/cs_lit", cs9, 32'h2008_0004);
        chk("t1/wc_run_lit", {wc9, run9}, {10'd2, 1'b1});
        loadT1(); runLoad(0, 1, "t2");

        // Reset in the middle of a word: nothing is written, everything clears.
        obsQ.delete();
        @(negedge clk); start9 = 1'b1;
        @(negedge clk); start9 = 1'b0; setByte(0, 1'b1, 8'h20);
        @(negedge clk); setByte(0, 1'b1, 8'h08);
        @(negedge clk); setByte(0, 1'b0, 8'h00); rst_n = 1'b0;
        #1; checkReset(0, "t5rst");
        @(negedge clk); @(negedge clk);
        chk("t5/nowr", 64'(obsQ.size()), 0);
        rst_n = 1'b1;
        @(negedge clk); checkReset(0, "t5rel");
        loadT1(); runLoad(0, 0, "t5");
        chk("t5/cs_lit", cs9, 32'h2008_0004);

        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        runLoad(0, 0, "t6");
        chk("t6/cs_lit", cs9, 32'h1234_5677);

        stream.delete();
        repeat (16) stream.push_back(8'h00);
        runLoad(1, 0, "t3");
        chk("t3/lit", {ovf2, run2, wc2}, {1'b1, 1'b0, 3'd4});

        stream.delete();
        repeat (12) stream.push_back(8'h00);
        repeat (4) stream.push_back(8'hFF);
        runLoad(1, 0, "t4");
        chk("t4/lit", {ovf2, run2, wc2}, {1'b0, 1'b1, 3'd4});

        for (int r = 0; r < 24; r++) begin
            sel = $urandom_range(1);
            stream.delete();
            if (sel == 0) begin
                nw = $urandom_range(1, 8); halt = 1;
            end else begin
                halt = $urandom_range(1);
                nw = halt ? $urandom_range(1, 4) : $urandom_range(4, 5);
            end
            for (int i = 0; i < nw; i++) begin
                if (i == nw-1 && halt)         w = HALT;
                else if ($urandom_range(9) == 0) w = HALT;
                else                            w = $urandom();
                stream.push_back(w[31:24]); stream.push_back(w[23:16]);
                stream.push_back(w[15:8]);  stream.push_back(w[7:0]);
            end
            runLoad(sel, $urandom_range(2), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
